// File: rtl/rv32i_fetch_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch front end.
// Word width, NOP encoding, default reset PC and the fetch FSM states.
package rv32i_fetch_ctrl_pkg;

  localparam int RV32I_INSTRUCTION_WIDTH = 32;

  typedef logic [RV32I_INSTRUCTION_WIDTH-1:0] word_t;

  localparam word_t RV32I_NOP      = 32'h0000_0013;
  localparam word_t RV32I_RESET_PC = 32'h0040_0000;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DROP,
    HALTED
  } fetch_state_t;

  function automatic logic is_aligned(input word_t a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_fetch_ctrl_pc.sv
// Fetch PC register: reset, sequential +4 and redirect load.
// Also reports whether the redirect target is word aligned.
module rv32i_fetch_ctrl_pc
  import rv32i_fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_PC = RV32I_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] ld_pc,
  input  logic        inc,
  output logic [31:0] pc,
  output logic        ld_ok
);

  assign ld_ok = is_aligned(ld_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (ld) begin
      pc <= ld_pc;
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I fetch sequencer: one outstanding imem request, holds the
// fetched word for decode, handles redirect, halt and target faults.
module rv32i_fetch_ctrl
  import rv32i_fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_PC = RV32I_RESET_PC,
  parameter word_t NOP_WORD = RV32I_NOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  output logic [31:0] dec_raw_bits,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_fault
);

  fetch_state_t state, state_n;
  logic         pend, pend_n;
  logic         dv, dv_n;
  word_t        raw, raw_n;
  word_t        dpc, dpc_n;
  logic         hlt, hlt_n;
  logic         flt, flt_n;

  word_t pc;
  logic  ok;
  logic  pc_ld;
  logic  pc_inc;
  logic  redir;
  logic  accept;
  logic  busy;

  rv32i_fetch_ctrl_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .ld   (pc_ld),
    .ld_pc(redirect_pc),
    .inc  (pc_inc),
    .pc   (pc),
    .ld_ok(ok)
  );

  // A fault freezes the front end; only rst can restart it.
  assign redir  = redirect_valid && !flt;
  assign accept = (state == REQ) && imem_req_ready;
  assign busy   = accept
               || ((state == WAIT || state == DROP)
                   && !imem_rsp_valid);

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_req_addr  = pc;
  assign dec_valid      = dv;
  assign dec_raw_bits   = raw;
  assign dec_pc         = dpc;
  assign halted         = hlt;
  assign fetch_fault    = flt;

  always_comb begin
    state_n = state;
    pend_n  = pend;
    dv_n    = dv;
    raw_n   = raw;
    dpc_n   = dpc;
    hlt_n   = hlt;
    flt_n   = flt;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    if (redir) begin
      dv_n   = 1'b0;
      raw_n  = NOP_WORD;
      pend_n = 1'b0;
      if (ok) begin
        pc_ld   = 1'b1;
        hlt_n   = 1'b0;
        state_n = busy ? DROP : REQ;
      end else begin
        flt_n   = 1'b1;
        hlt_n   = 1'b1;
        pend_n  = busy;
        state_n = busy ? DROP : HALTED;
      end
    end else if (halt_req && state != HALTED) begin
      dv_n    = 1'b0;
      raw_n   = NOP_WORD;
      hlt_n   = 1'b1;
      pend_n  = busy;
      state_n = busy ? DROP : HALTED;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_req_ready) state_n = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            dv_n    = 1'b1;
            raw_n   = imem_rsp_data;
            dpc_n   = pc;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (dec_ready) begin
            pc_inc  = 1'b1;
            dv_n    = 1'b0;
            raw_n   = NOP_WORD;
            state_n = REQ;
          end
        end
        DROP: begin
          // pend routes a halt or fault through here first.
          if (imem_rsp_valid) begin
            pend_n  = 1'b0;
            state_n = pend ? HALTED : REQ;
          end
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: begin
          state_n = REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pend  <= 1'b0;
      dv    <= 1'b0;
      raw   <= NOP_WORD;
      dpc   <= RESET_PC;
      hlt   <= 1'b0;
      flt   <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      dv    <= dv_n;
      raw   <= raw_n;
      dpc   <= dpc_n;
      hlt   <= hlt_n;
      flt   <= flt_n;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Scoreboard bench for rv32i_fetch_ctrl: directed scenarios then
// randomized flow changes against an architectural PC model.
module tb_rv32i_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_raw_bits;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        fetch_fault;

  rv32i_fetch_ctrl #(
    .RESET_PC(RST_PC),
    .NOP_WORD(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_raw_bits  (dec_raw_bits),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int consumed = 0;

  logic [31:0] m_pc = RST_PC;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;
  bit          seen = 1'b0;
  bit          started = 1'b0;
  exp_t        q[$];

  int rdy_pct = 100;
  int dmin = 0;
  int dmax = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h6a09_e667;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic wait_dec(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dec_valid) return;
    end
    tmo(nm);
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) return;
    end
    tmo(nm);
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = t;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic consume_one();
    cyc();
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
  endtask

  // Memory: one response per accepted request after dmin..dmax cycles.
  initial begin : memory
    bit          mp;
    int          md;
    logic [31:0] ma;
    mp = 1'b0;
    md = 0;
    ma = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mp = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        mp = 1'b1;
        ma = imem_req_addr;
        md = int'($urandom_range(dmax, dmin));
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (mp) begin
        if (md == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(ma);
          mp = 1'b0;
        end else begin
          md--;
        end
      end
      imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    end
  end

  // Monitor and architectural model: the fetch address is always the
  // next PC in program order; flow changes discard anything unconsumed.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (dec_valid) begin
          if (!seen) begin
            if (q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL sb_spurious: got pc %08h required none",
                       dec_pc);
            end else begin
              e = q.pop_front();
              chk("sb_pc", dec_pc, e.pc);
              chk("sb_raw", dec_raw_bits, e.w);
            end
            seen = 1'b1;
          end
        end else begin
          chk("idle_nop", dec_raw_bits, NOP);
        end
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
        chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_halt) chk("halt_noreq", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
        if (imem_req_valid && imem_req_ready) begin
          e.pc = m_pc;
          e.w  = mem_word(m_pc);
          q.push_back(e);
        end
        if (rst) begin
          m_pc    = RST_PC;
          m_halt  = 1'b0;
          m_fault = 1'b0;
          seen    = 1'b0;
          q.delete();
        end else if (redirect_valid && !m_fault) begin
          q.delete();
          seen = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            m_pc   = redirect_pc;
            m_halt = 1'b0;
          end else begin
            m_fault = 1'b1;
            m_halt  = 1'b1;
          end
        end else if (halt_req && !m_halt) begin
          q.delete();
          seen   = 1'b0;
          m_halt = 1'b1;
        end else if (dec_valid && dec_ready) begin
          m_pc = m_pc + 32'd4;
          seen = 1'b0;
          consumed++;
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] r;
    logic [31:0] t;
    rst            = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_raw", dec_raw_bits, NOP);
    chk("rst_dec_pc", dec_pc, RST_PC);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    cyc();
    rst     = 1'b0;
    started = 1'b1;

    // first fetch and in-order advance
    @(negedge clk);
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_req_addr", imem_req_addr, RST_PC);
    wait_dec("t1_dec");
    chk("t1_raw", dec_raw_bits, 32'h0050_0093);
    chk("t1_pc", dec_pc, RST_PC);
    consume_one();
    wait_req("t1_req");
    chk("t1_next", imem_req_addr, 32'h0040_0004);

    // decode backpressure holds the word
    wait_dec("t2_dec");
    cyc();
    repeat (5) begin
      @(negedge clk);
      chk("t2_valid", {31'b0, dec_valid}, 32'd1);
      chk("t2_pc", dec_pc, 32'h0040_0004);
      chk("t2_raw", dec_raw_bits, mem_word(32'h0040_0004));
      chk("t2_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    dmin = 2;
    dmax = 2;
    consume_one();
    wait_req("t2_req");
    chk("t2_next", imem_req_addr, 32'h0040_0008);

    // redirect while the response is outstanding
    pulse_redirect(32'h0040_0100);
    @(negedge clk);
    chk("t3_drop_noreq", {31'b0, imem_req_valid}, 32'd0);
    chk("t3_drop_dv", {31'b0, dec_valid}, 32'd0);
    dmin = 0;
    dmax = 1;
    wait_req("t3_req");
    chk("t3_addr", imem_req_addr, 32'h0040_0100);
    chk("t3_dv", {31'b0, dec_valid}, 32'd0);

    // halt while holding, then restart by redirect
    wait_dec("t5_dec");
    cyc();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    @(negedge clk);
    chk("t5_dv", {31'b0, dec_valid}, 32'd0);
    chk("t5_halted", {31'b0, halted}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("t5_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    pulse_redirect(32'h0040_0200);
    @(negedge clk);
    chk("t5_unhalt", {31'b0, halted}, 32'd0);
    chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t5_addr", imem_req_addr, 32'h0040_0200);

    // PC wraps past the top of the address space
    pulse_redirect(32'hFFFF_FFFC);
    wait_dec("t6_dec");
    chk("t6_pc", dec_pc, 32'hFFFF_FFFC);
    chk("t6_raw", dec_raw_bits, mem_word(32'hFFFF_FFFC));
    dmin = 3;
    dmax = 3;
    consume_one();
    wait_req("t6_req");
    chk("t6_wrap", imem_req_addr, 32'h0000_0000);

    // reset in the middle of a transaction
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dmin = 0;
    dmax = 1;
    @(negedge clk);
    chk("t6_rst_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_rst_addr", imem_req_addr, RST_PC);
    chk("t6_rst_dv", {31'b0, dec_valid}, 32'd0);

    // misaligned target is fatal until reset
    pulse_redirect(32'h0040_0102);
    @(negedge clk);
    chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t4_halted", {31'b0, halted}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("t4_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    pulse_redirect(32'h0040_0300);
    repeat (3) begin
      @(negedge clk);
      chk("t4_stuck", {31'b0, halted}, 32'd1);
      chk("t4_stuck_req", {31'b0, imem_req_valid}, 32'd0);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_clear", {31'b0, fetch_fault}, 32'd0);

    // randomized flow
    rdy_pct = 60;
    dmin = 0;
    dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = m_fault ? ($urandom_range(9, 0) == 0)
                    : ($urandom_range(299, 0) == 0);
      dec_ready      = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(39, 0) == 0);
      halt_req       = ($urandom_range(99, 0) == 0);
      r = $urandom;
      t = ($urandom_range(7, 0) == 0) ? r : {r[31:2], 2'b00};
      if ($urandom_range(15, 0) == 0) t = 32'hFFFF_FFF8;
      redirect_pc = t;
    end
    cyc();
    rst            = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (consumed < 100) begin
      n_fail++;
      $display("FAIL liveness: got %0d consumed required >= 100",
               consumed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
